// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/breakpoint controller for the board-level MIPS CPU. Produces a
//   one-cycle clock enable for the core (which runs on CLK100MHZ with an enable
//   rather than a gated clock) and counts executed instructions.
//
// Ports
//   CLK100MHZ  in   1      board clock, sole clock
//   rst_n      in   1      asynchronous active-low reset
//   mode       in   2      raw switches: 00 HALT, 01 STEP, 10 RUN, 11 RUN_BP
//   step_btn   in   1      raw push button, asynchronous, active-high
//   bp_en      in   1      breakpoint enable (only consulted in RUN_BP)
//   bp_addr    in   PC_W   breakpoint PC
//   pc         in   PC_W   PC of the next instruction the core will execute
//   cpu_ce     out  1      one-cycle enable, one instruction per pulse
//   bp_hit     out  1      high while stopped at a breakpoint
//   state      out  2      0 HALT, 1 STEP, 2 RUN, 3 BREAK
//   retired    out  CNT_W  cpu_ce pulses since reset (wraps)
module cpu_run_ctrl #(
  parameter int RUN_DIV      = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             bp_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_BREAK = 2'd3;

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  // Two-flop synchronisers for the asynchronous board inputs.
  logic [1:0]       mode_s1_q, mode_s2_q;
  logic             btn_s1_q, btn_s2_q;

  // Debouncer.
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             step_req_q, step_req_d;

  // Run-control FSM and outputs.
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [1:0]       mode_tgt;
  logic             fire;
  logic             bp_match;

  // The counter tracks consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts it, so only a stable new level wins.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    step_req_d = 1'b0;
    if (btn_s2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = '0;
      db_level_d = btn_s2_q;
      step_req_d = btn_s2_q;   // only an accepted press, never a release
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // State the synced switches ask for; RUN and RUN_BP share the RUN state.
  always_comb begin
    case (mode_s2_q)
      2'b00:   mode_tgt = S_HALT;
      2'b01:   mode_tgt = S_STEP;
      default: mode_tgt = S_RUN;
    endcase
  end

  assign fire     = (div_q == DIV_LAST);
  assign bp_match = (mode_s2_q == 2'b11) && bp_en && (pc == bp_addr);

  // Mode changes are tested first in every state, so a step request landing
  // in the same cycle is dropped. The divider idles at zero outside RUN,
  // which makes every entry into RUN start a fresh period.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    ce_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (mode_tgt != S_HALT) state_d = mode_tgt;
      end
      S_STEP: begin
        if (mode_tgt != S_STEP) state_d = mode_tgt;
        else if (step_req_q)    ce_d    = 1'b1;
      end
      S_RUN: begin
        if (mode_tgt != S_RUN) begin
          state_d = mode_tgt;
        end else begin
          div_d = fire ? '0 : div_q + DIV_W'(1);
          if (fire) begin
            // The breakpoint instruction itself is held back.
            if (bp_match) state_d = S_BREAK;
            else          ce_d    = 1'b1;
          end
        end
      end
      default: begin // S_BREAK
        if (mode_s2_q != 2'b11) begin
          state_d = mode_tgt;
        end else if (step_req_q) begin
          // Execute the breakpoint instruction, then resume running.
          ce_d    = 1'b1;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // Counted with the pulse itself so retired and cpu_ce move together.
  assign retired_d = ce_d ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q  <= 2'b00;
      mode_s2_q  <= 2'b00;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      step_req_q <= 1'b0;
      state_q    <= S_HALT;
      div_q      <= '0;
      ce_q       <= 1'b0;
      retired_q  <= '0;
    end else begin
      mode_s1_q  <= mode;
      mode_s2_q  <= mode_s1_q;
      btn_s1_q   <= step_btn;
      btn_s2_q   <= btn_s1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      step_req_q <= step_req_d;
      state_q    <= state_d;
      div_q      <= div_d;
      ce_q       <= ce_d;
      retired_q  <= retired_d;
    end
  end

  assign cpu_ce  = ce_q;
  assign bp_hit  = (state_q == S_BREAK);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
//   Scenario-per-task bench for cpu_run_ctrl (RUN_DIV=4, DEBOUNCE_CYC=8,
//   8-bit PC and counter). Expected values come from simple timing rules:
//   a clean press pulses 11 cycles later, RUN pulses every RUN_DIV cycles
//   after entry, a breakpoint at 4k stops after k pulses from pc=0.
module tb_cpu_run_ctrl;

  localparam int RUN_DIV = 4;
  localparam int DB      = 8;
  localparam int PRESS_LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       step_btn;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic [7:0] pc;
  logic       cpu_ce;
  logic       bp_hit;
  logic [1:0] state;
  logic [7:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retired = 0;
  bit pc_track = 1'b0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RUN_DIV(RUN_DIV), .DEBOUNCE_CYC(DB), .PC_W(8), .CNT_W(8)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .mode(mode), .step_btn(step_btn),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce),
    .bp_hit(bp_hit), .state(state), .retired(retired)
  );

  // One clock; the core model advances its PC on every enable it sees.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_ce === 1'b1 && pc_track) pc = pc + 8'd4;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (state === s) break;
      tick();
    end
    n_checks++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d expected %0d", name, state, s);
    end
  endtask

  task automatic check_retired(input string name);
    n_checks++;
    if (retired !== 8'(exp_retired)) begin
      n_fail++;
      $display("FAIL %s: retired=%0d expected %0d", name, retired, exp_retired % 256);
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; mode = 2'b00; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = 8'h00; pc = 8'h00;
    repeat (3) tick();
    n_checks++;
    if (cpu_ce !== 1'b0 || state !== 2'd0 || retired !== 8'd0 || bp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ce=%b state=%0d retired=%0d bp_hit=%b expected 0/0/0/0",
               cpu_ce, state, retired, bp_hit);
    end
    rst_n = 1'b1;
    mode = 2'b10;
    wait_state(2'd2, 10, "reset_run_enter");
    for (int i = 0; i < 10; i++) begin
      if (cpu_ce === 1'b1) break;
      tick();
    end
    n_checks++;
    if (cpu_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_run_pulse: cpu_ce=%b expected 1", cpu_ce);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cpu_ce !== 1'b0 || state !== 2'd0 || retired !== 8'd0 || bp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: ce=%b state=%0d retired=%0d bp_hit=%b expected 0/0/0/0",
               cpu_ce, state, retired, bp_hit);
    end
    mode = 2'b00;
    tick();
    rst_n = 1'b1;
    exp_retired = 0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL reset_halt_idle: pulses=%0d expected 0", cnt);
    end
    check_retired("reset_retired");
    $display("test_reset done");
  endtask

  task automatic test_step();
    int cnt, lat, blen;
    mode = 2'b01;
    wait_state(2'd1, 10, "step_enter");
    // clean 20-cycle press
    step_btn = 1'b1; cnt = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ce === 1'b1) begin cnt++; if (lat < 0) lat = i; end
    end
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 1 || lat != PRESS_LAT) begin
      n_fail++;
      $display("FAIL step_clean: pulses=%0d latency=%0d expected 1 / %0d", cnt, lat, PRESS_LAT);
    end
    exp_retired += 1;
    check_retired("step_clean_retired");
    // bounce shorter than the debounce window
    blen = $urandom_range(1, DB - 1);
    step_btn = 1'b1;
    repeat (blen) tick();
    step_btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL step_bounce: len=%0d pulses=%0d expected 0", blen, cnt);
    end
    // long hold: one pulse only
    step_btn = 1'b1; cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL step_hold: pulses=%0d expected 1", cnt);
    end
    exp_retired += 1;
    check_retired("step_hold_retired");
    mode = 2'b00;
    wait_state(2'd0, 10, "step_exit");
    $display("test_step done (bounce %0d cycles)", blen);
  endtask

  task automatic test_run(input int n);
    int cnt, misplaced, late, tail, tail_exp;
    mode = 2'b10;
    wait_state(2'd2, 10, "run_enter");
    cnt = 0; misplaced = 0;
    for (int m = 1; m <= n; m++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        cnt++;
        if (m % RUN_DIV != 0) misplaced++;
      end
    end
    n_checks++;
    if (cnt != n / RUN_DIV || misplaced != 0) begin
      n_fail++;
      $display("FAIL run_pulses: n=%0d pulses=%0d off-grid=%0d expected %0d / 0",
               n, cnt, misplaced, n / RUN_DIV);
    end
    exp_retired += n / RUN_DIV;
    // Two more cycles still run while the new mode crosses the synchroniser.
    mode = 2'b00;
    tail = 0; late = 0; tail_exp = 0;
    for (int m = n + 1; m <= n + 20; m++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        tail++;
        if (m > n + 2) late++;
      end
      if (m <= n + 2 && m % RUN_DIV == 0) tail_exp++;
    end
    n_checks++;
    if (tail != tail_exp || late != 0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL run_stop: tail=%0d late=%0d state=%0d expected %0d / 0 / 0",
               tail, late, state, tail_exp);
    end
    exp_retired += tail_exp;
    check_retired("run_retired");
    $display("test_run done (n=%0d)", n);
  endtask

  task automatic test_breakpoint(input int k);
    int cnt, p1, p2, bad;
    logic [7:0] pc_at_p1;
    pc = 8'h00; pc_track = 1'b1;
    bp_en = 1'b1; bp_addr = 8'(4 * k);
    mode = 2'b11;
    cnt = 0;
    for (int i = 0; i < 4 * (k + 1) + 20; i++) begin
      if (state === 2'd3) break;
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (state !== 2'd3 || bp_hit !== 1'b1 || cnt != k || pc !== 8'(4 * k)) begin
      n_fail++;
      $display("FAIL bp_stop: state=%0d bp_hit=%b pulses=%0d pc=%0h expected 3 / 1 / %0d / %0h",
               state, bp_hit, cnt, pc, k, 4 * k);
    end
    exp_retired += k;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_hold: pulses=%0d state=%0d expected 0 / 3", cnt, state);
    end
    // Step out: bp instruction at PRESS_LAT, then RUN pulses on a fresh grid.
    step_btn = 1'b1;
    cnt = 0; p1 = -1; p2 = -1; bad = 0; pc_at_p1 = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20) begin step_btn = 1'b0; mode = 2'b00; end
      if (cpu_ce === 1'b1) begin
        cnt++;
        if (p1 < 0) begin p1 = i; pc_at_p1 = pc; end
        else if (p2 < 0) p2 = i;
        if (i < PRESS_LAT || (i - PRESS_LAT) % RUN_DIV != 0) bad++;
      end
      if (i == PRESS_LAT + 1) begin
        n_checks++;
        if (state !== 2'd2 || bp_hit !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_resume: state=%0d bp_hit=%b expected 2 / 0", state, bp_hit);
        end
      end
    end
    n_checks++;
    if (p1 != PRESS_LAT || p2 != PRESS_LAT + RUN_DIV || pc_at_p1 !== 8'(4 * k + 4) ||
        cnt != 3 || bad != 0) begin
      n_fail++;
      $display("FAIL bp_step: p1=%0d p2=%0d pc=%0h pulses=%0d bad=%0d expected %0d / %0d / %0h / 3 / 0",
               p1, p2, pc_at_p1, cnt, bad, PRESS_LAT, PRESS_LAT + RUN_DIV, 4 * k + 4);
    end
    exp_retired += 3;
    check_retired("bp_retired");
    pc_track = 1'b0; bp_en = 1'b0;
    $display("test_breakpoint done (bp_addr=%0h)", 4 * k);
  endtask

  task automatic test_edges();
    int cnt, p, n;
    // step request and mode change reach the FSM in the same cycle
    mode = 2'b01;
    wait_state(2'd1, 10, "edge_step_enter");
    step_btn = 1'b1;
    repeat (PRESS_LAT - 3) tick();
    mode = 2'b00;
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL edge_same_cycle: pulses=%0d state=%0d expected 0 / 0", cnt, state);
    end
    step_btn = 1'b0;
    repeat (20) tick();
    // counter wrap
    p = (255 - exp_retired) & 255;
    if (p == 0) p = 256;
    mode = 2'b10;
    wait_state(2'd2, 10, "edge_wrap_enter");
    cnt = 0;
    for (int i = 0; i < p * RUN_DIV; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    mode = 2'b00;
    repeat (20) tick();
    n_checks++;
    if (cnt != p) begin
      n_fail++;
      $display("FAIL edge_wrap_fill: pulses=%0d expected %0d", cnt, p);
    end
    exp_retired = (exp_retired + p) & 255;
    check_retired("edge_retired_ff");
    mode = 2'b10;
    wait_state(2'd2, 10, "edge_wrap2_enter");
    repeat (RUN_DIV + 1) tick();
    mode = 2'b00;
    exp_retired = (exp_retired + 1) & 255;
    check_retired("edge_retired_wrap");
    repeat (20) tick();
    // bp_en=0 in RUN_BP with pc sitting on bp_addr
    pc = 8'($urandom_range(0, 255));
    bp_addr = pc; bp_en = 1'b0;
    mode = 2'b11;
    wait_state(2'd2, 10, "edge_nobp_enter");
    n = $urandom_range(20, 40);
    cnt = 0; p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_ce === 1'b1) cnt++;
      if (state === 2'd3) p++;
    end
    n_checks++;
    if (cnt != n / RUN_DIV || p != 0) begin
      n_fail++;
      $display("FAIL edge_bp_disabled: pulses=%0d break_cycles=%0d expected %0d / 0",
               cnt, p, n / RUN_DIV);
    end
    exp_retired += n / RUN_DIV;
    // enabling it now stops at the very next fire point without a pulse
    bp_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < RUN_DIV + 2; i++) begin
      if (state === 2'd3) break;
      tick();
      if (cpu_ce === 1'b1) cnt++;
    end
    n_checks++;
    if (state !== 2'd3 || cnt != 0) begin
      n_fail++;
      $display("FAIL edge_bp_enable: state=%0d pulses=%0d expected 3 / 0", state, cnt);
    end
    mode = 2'b00; bp_en = 1'b0;
    wait_state(2'd0, 10, "edge_exit");
    n_checks++;
    if (bp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_bp_clear: bp_hit=%b expected 0", bp_hit);
    end
    check_retired("edge_final_retired");
    $display("test_edges done (nobp n=%0d)", n);
  endtask

  initial begin
    test_reset();
    test_step();
    test_run(40);
    test_run($urandom_range(20, 60));
    test_breakpoint(4);
    test_breakpoint($urandom_range(2, 7));
    test_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
